// File: rtl/onehot_bus_arbiter.sv
// onehot_bus_arbiter: round-robin selector of N request channels into one registered output with backpressure and conflict stats
module onehot_bus_arbiter #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [N-1:0]         Req,
    input  logic [N*WIDTH-1:0]   Data_In,
    input  logic                 Out_Ready,
    input  logic                 Clr_Conflict,
    output logic [N-1:0]         Grant,
    output logic [WIDTH-1:0]     Q_Out,
    output logic                 Out_Valid,
    output logic                 Conflict,
    output logic [7:0]           Conflict_Count
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]    ptr_q, ptr_d, win;
    logic [2*N-1:0]   req_rot2, gnt_rot2;
    logic [N-1:0]     rot, first, gnt;
    logic [WIDTH-1:0] q_out_q, q_out_d, sel;
    logic             out_valid_q, out_valid_d, conflict_q, conflict_d, load, multi;
    logic [7:0]       count_q, count_d;
    logic [WIDTH-1:0] ch [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ch
            assign ch[g] = Data_In[g*WIDTH +: WIDTH];
        end
    endgenerate

    // rotate requests so the pointer sits at bit 0, pick the lowest set bit, rotate back, then compute next state
    always_comb begin
        load        = (|Req) && (!out_valid_q || Out_Ready) && Reset_n;
        multi       = |(Req & (Req - 1'b1));
        req_rot2    = {Req, Req} >> ptr_q;
        rot         = req_rot2[N-1:0];
        first       = rot & (~rot + 1'b1);
        gnt_rot2    = {first, first} << ptr_q;
        gnt         = gnt_rot2[2*N-1:N];
        Grant       = load ? gnt : '0;
        win         = '0;
        sel         = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win = PW'(i);
                sel = ch[i];
            end
        end
        q_out_d     = load ? sel : q_out_q;
        out_valid_d = load ? 1'b1 : (Out_Ready ? 1'b0 : out_valid_q);
        ptr_d       = load ? ((win == PW'(N-1)) ? '0 : win + 1'b1) : ptr_q;
        conflict_d  = Clr_Conflict ? 1'b0 : ((load && multi) ? 1'b1 : conflict_q);
        count_d     = Clr_Conflict ? 8'd0 : ((load && multi && count_q != 8'hFF) ? count_q + 8'd1 : count_q);
    end

    // state registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q       <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            ptr_q       <= ptr_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            conflict_q  <= conflict_d;
            count_q     <= count_d;
        end
    end

    assign Q_Out          = q_out_q;
    assign Out_Valid      = out_valid_q;
    assign Conflict       = conflict_q;
    assign Conflict_Count = count_q;
endmodule
